// File: rtl/dram_rst_sequencer.sv
// DDR3 power-up reset sequencer: lock filter, RESET# hold, CKE hold, release.
// Optional DRAM_RST_SEQ_SOFT_RST_EN adds a soft_rst input restarting at HOLD_RST.
`timescale 1ns/1ps
module dram_rst_sequencer #(
  parameter int LOCK_FILTER  = 256,
  parameter int RESET_CYCLES = 20000,
  parameter int CKE_CYCLES   = 44000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
`ifdef DRAM_RST_SEQ_SOFT_RST_EN
  input  logic       soft_rst,
`endif
  output logic       ddr_reset_n,
  output logic       ddr_cke,
  output logic       dramsync_rst,
  output logic       init_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    HOLD_RST  = 3'd2,
    HOLD_CKE  = 3'd3,
    DONE      = 3'd4
  } st_e;

  localparam logic [CNT_W-1:0] LF_M1 =
    CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] RC_M1 =
    CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CK_M1 =
    CNT_W'(CKE_CYCLES - 1);

  st_e              st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1, lock_s;
  logic             rn_d, cke_d, drs_d, done_d;

  // two-flop synchroniser for the asynchronous lock indicator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  // next state and shared down-counter reload/decrement
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          st_d  = FILTER;
          cnt_d = LF_M1;
        end
      end
      FILTER: begin
        if (cnt_q == '0) begin
          st_d  = HOLD_RST;
          cnt_d = RC_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD_RST: begin
        if (cnt_q == '0) begin
          st_d  = HOLD_CKE;
          cnt_d = CK_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD_CKE: begin
        if (cnt_q == '0) begin
          st_d  = DONE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        st_d  = DONE;
        cnt_d = '0;
      end
      default: begin
        st_d  = WAIT_LOCK;
        cnt_d = '0;
      end
    endcase
`ifdef DRAM_RST_SEQ_SOFT_RST_EN
    if (soft_rst) begin
      st_d  = HOLD_RST;
      cnt_d = RC_M1;
    end
`endif
    if (!lock_s) begin
      st_d  = WAIT_LOCK;
      cnt_d = '0;
    end
  end

  // output values for the state being entered
  always_comb begin
    rn_d   = 1'b0;
    cke_d  = 1'b0;
    drs_d  = 1'b1;
    done_d = 1'b0;
    case (st_d)
      HOLD_CKE: begin
        rn_d = 1'b1;
      end
      DONE: begin
        rn_d   = 1'b1;
        cke_d  = 1'b1;
        drs_d  = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        rn_d = 1'b0;
      end
    endcase
  end

  // state, counter and outputs registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= WAIT_LOCK;
      cnt_q        <= '0;
      ddr_reset_n  <= 1'b0;
      ddr_cke      <= 1'b0;
      dramsync_rst <= 1'b1;
      init_done    <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      ddr_reset_n  <= rn_d;
      ddr_cke      <= cke_d;
      dramsync_rst <= drs_d;
      init_done    <= done_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_dram_rst_sequencer.sv
// Bench for dram_rst_sequencer: default-timing run plus small-parameter
// scenarios checked cycle by cycle against a queue of expected outputs.
`timescale 1ns/1ps
module tb_dram_rst_sequencer;

  localparam int LF = 4;
  localparam int RC = 5;
  localparam int CK = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  string cur = "";

  // default-parameter instance
  logic       rst_n1 = 1'b0;
  logic       pll1   = 1'b1;
  logic       rn1, cke1, drs1, done1;
  logic [2:0] st1;

  // small-parameter instance
  logic       rst_n2 = 1'b0;
  logic       pll2   = 1'b0;
  logic       rn2, cke2, drs2, done2;
  logic [2:0] st2;
`ifdef DRAM_RST_SEQ_SOFT_RST_EN
  logic       soft2 = 1'b0;
`endif

  dram_rst_sequencer u_def (
    .clk          (clk),
    .rst_n        (rst_n1),
    .pll_locked   (pll1),
`ifdef DRAM_RST_SEQ_SOFT_RST_EN
    .soft_rst     (1'b0),
`endif
    .ddr_reset_n  (rn1),
    .ddr_cke      (cke1),
    .dramsync_rst (drs1),
    .init_done    (done1),
    .state        (st1)
  );

  dram_rst_sequencer #(
    .LOCK_FILTER  (LF),
    .RESET_CYCLES (RC),
    .CKE_CYCLES   (CK),
    .CNT_W        (8)
  ) u_sml (
    .clk          (clk),
    .rst_n        (rst_n2),
    .pll_locked   (pll2),
`ifdef DRAM_RST_SEQ_SOFT_RST_EN
    .soft_rst     (soft2),
`endif
    .ddr_reset_n  (rn2),
    .ddr_cke      (cke2),
    .dramsync_rst (drs2),
    .init_done    (done2),
    .state        (st2)
  );

  logic [6:0] sb[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // {ddr_reset_n, ddr_cke, dramsync_rst, init_done, state}
  function automatic logic [6:0] ev(input int s);
    case (s)
      3:       ev = {4'b1010, 3'd3};
      4:       ev = {4'b1101, 3'd4};
      default: ev = {4'b0010, 3'(s)};
    endcase
  endfunction

  function automatic logic [6:0] obs2();
    obs2 = {rn2, cke2, drs2, done2, st2};
  endfunction

  task automatic push_run(input int z, input int a,
                          input int b, input int c,
                          input bit done);
    for (int i = 0; i < z; i++) sb.push_back(ev(0));
    for (int i = 0; i < a; i++) sb.push_back(ev(1));
    for (int i = 0; i < b; i++) sb.push_back(ev(2));
    for (int i = 0; i < c; i++) sb.push_back(ev(3));
    if (done) sb.push_back(ev(4));
  endtask

  task automatic step();
    @(negedge clk);
    if (sb.size() > 0)
      check(cur, 32'(obs2()), 32'(sb.pop_front()));
  endtask

  // drain queue; pll2 set to v1 after step a1 and v2 after step a2
  task automatic run_q(input int a1, input bit v1,
                       input int a2, input bit v2);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      if (i == a1) pll2 = v1;
      if (i == a2) pll2 = v2;
    end
  endtask

  task automatic do_reset();
    rst_n2 = 1'b0;
    pll2   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n2 = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_default();
    longint tr, tc, td;
    bit sr, sc, sd;
    tr = 0; tc = 0; td = 0;
    sr = 0; sc = 0; sd = 0;
    #50;
    check("def_reset", {rn1, cke1, drs1, done1, st1},
          32'(ev(0)));
    #50 rst_n1 = 1'b1;
    for (int i = 0; i < 70000 && !sd; i++) begin
      @(negedge clk);
      if (!sr && rn1)   begin tr = $time - 5; sr = 1; end
      if (!sc && cke1)  begin tc = $time - 5; sc = 1; end
      if (!sd && !drs1) begin td = $time - 5; sd = 1; end
    end
    check("def_seen", {29'd0, sr, sc, sd}, 32'd7);
    check("def_rstn_rise", 32'(tr), 32'd202685);
    check("def_window",
          32'(td >= 600000 && td <= 700000), 32'd1);
    check("def_drs_fall_tol",
          32'(td >= 642665 && td <= 642705), 32'd1);
    check("def_cke_same", 32'(tc), 32'(td));
    check("def_done", {29'd0, done1, st1}, 32'h0c);
  endtask

  task automatic run_small();
    repeat (2) @(negedge clk);
    cur = "reset";
    check(cur, 32'(obs2()), 32'(ev(0)));
    rst_n2 = 1'b1;

    cur = "idle";
    push_run(3, 0, 0, 0, 0);
    run_q(0, 0, 0, 0);

    cur = "nominal";
    pll2 = 1'b1;
    push_run(2, LF, RC, CK, 1);
    run_q(0, 0, 0, 0);
    cur = "hold_done";
    push_run(0, 0, 0, 0, 1);
    run_q(0, 0, 0, 0);

    cur = "glitch";
    do_reset();
    pll2 = 1'b1;
    push_run(2, 4, 0, 0, 0);
    push_run(2, 0, 0, 0, 0);
    push_run(0, LF, RC, CK, 1);
    run_q(4, 1'b0, 6, 1'b1);

    cur = "cke_loss";
    do_reset();
    pll2 = 1'b1;
    push_run(2, LF, RC, CK, 0);
    push_run(4, LF, RC, CK, 1);
    run_q(12, 1'b0, 16, 1'b1);

    cur = "async_pre";
    do_reset();
    pll2 = 1'b1;
    push_run(2, LF, RC, CK, 1);
    for (int i = 0; i < 8; i++) step();
    sb.delete();
    #2 rst_n2 = 1'b0;
    #1 check("async_rst", 32'(obs2()), 32'(ev(0)));
    repeat (2) @(negedge clk);
    rst_n2 = 1'b1;
    cur = "async_restart";
    push_run(2, LF, RC, CK, 1);
    run_q(0, 0, 0, 0);

`ifdef DRAM_RST_SEQ_SOFT_RST_EN
    cur = "soft_pulse";
    soft2 = 1'b1;
    push_run(0, 0, RC, CK, 1);
    for (int i = 1; sb.size() > 0; i++) begin
      step();
      if (i == 1) soft2 = 1'b0;
    end
`endif
  endtask

  initial begin
    fork
      run_default();
      run_small();
    join
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
